// File: rtl/record_buffer.sv
// record_buffer: captures deserializer sample words into block RAM while
// recording, then replays them one word per request up to the recorded length.
module record_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              record_i,
  input  logic              play_i,
  input  logic              stop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  input  logic              play_req_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic [1:0]        state_o,
  output logic              full_o,
  output logic              done_o,
  output logic [ADDR_W:0]   length_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    PLAY   = 2'b10
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   length;
  logic              full;
  logic              done;
  logic              data_valid;
  logic              data_seen;

  // Single-port storage: one shared address, writes only while recording,
  // reads only while playing.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;

  logic start_rec;
  logic start_play;
  logic empty_play;
  logic do_write;
  logic do_read;
  logic last_write;
  logic last_read;

  // Next-state and control decode for capture / replay sequencing.
  always_comb begin
    next_state = state;
    start_rec  = 1'b0;
    start_play = 1'b0;
    empty_play = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    last_write = 1'b0;
    last_read  = 1'b0;
    ram_addr   = rd_ptr;
    case (state)
      IDLE: begin
        if (record_i) begin
          // record wins over a simultaneous play request
          next_state = RECORD;
          start_rec  = 1'b1;
        end else if (play_i) begin
          if (length != '0) begin
            next_state = PLAY;
            start_play = 1'b1;
          end else begin
            empty_play = 1'b1;
          end
        end else begin
          next_state = IDLE;
        end
      end
      RECORD: begin
        ram_addr = wr_ptr;
        if (data_valid_i) begin
          do_write = 1'b1;
          if (wr_ptr == {ADDR_W{1'b1}}) begin
            last_write = 1'b1;
          end else begin
            last_write = 1'b0;
          end
        end else begin
          do_write = 1'b0;
        end
        // a strobe coinciding with stop is still written above
        if (stop_i || last_write) begin
          next_state = IDLE;
        end else begin
          next_state = RECORD;
        end
      end
      PLAY: begin
        ram_addr = rd_ptr;
        if (stop_i) begin
          next_state = IDLE;
        end else if (play_req_i) begin
          do_read = 1'b1;
          if ({1'b0, rd_ptr} == (length - (ADDR_W+1)'(1))) begin
            last_read  = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = PLAY;
          end
        end else begin
          next_state = PLAY;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Pointers, recorded length, status flags and output strobes.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      length     <= '0;
      full       <= 1'b0;
      done       <= 1'b0;
      data_valid <= 1'b0;
      data_seen  <= 1'b0;
    end else begin
      done       <= last_read | empty_play;
      data_valid <= do_read;
      if (do_read) begin
        data_seen <= 1'b1;
      end
      if (start_rec) begin
        wr_ptr <= '0;
        length <= '0;
        full   <= 1'b0;
      end else if (do_write) begin
        // wr_ptr may roll over on the last write; state leaves RECORD then
        wr_ptr <= wr_ptr + ADDR_W'(1);
        length <= length + (ADDR_W+1)'(1);
        if (last_write) begin
          full <= 1'b1;
        end
      end
      if (start_play) begin
        rd_ptr <= '0;
      end else if (do_read) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Block RAM port: synchronous write or synchronous read, never both.
  always_ff @(posedge clock_i) begin
    if (do_write) begin
      mem[ram_addr] <= data_i;
    end else if (do_read) begin
      ram_q <= mem[ram_addr];
    end
  end

  // ram_q is not reset (keeps BRAM inference); mask it until the first read.
  assign data_o       = data_seen ? ram_q : '0;
  assign data_valid_o = data_valid;
  assign state_o      = state;
  assign full_o       = full;
  assign done_o       = done;
  assign length_o     = length;

endmodule

// File: tb/tb_record_buffer.sv
// tb_record_buffer: scoreboard bench for record_buffer (small ADDR_W so the
// full-memory boundary is reachable).
module tb_record_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              record;
  logic              play;
  logic              stop;
  logic [DATA_W-1:0] data_in;
  logic              data_valid_in;
  logic              play_req;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic [1:0]        state;
  logic              full;
  logic              done;
  logic [ADDR_W:0]   length;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int done_before;
  int valid_before;
  logic [DATA_W-1:0] exp_q [$];

  record_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .record_i     (record),
    .play_i       (play),
    .stop_i       (stop),
    .data_i       (data_in),
    .data_valid_i (data_valid_in),
    .play_req_i   (play_req),
    .data_o       (data_out),
    .data_valid_o (data_valid_out),
    .state_o      (state),
    .full_o       (full),
    .done_o       (done),
    .length_o     (length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every replayed word is compared against the queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid_out) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check_value("unexpected_valid", 32'd1, 32'd0);
        end else begin
          check_value("replay_data", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    reset = 1'b1; record = 1'b0; play = 1'b0; stop = 1'b0;
    data_in = '0; data_valid_in = 1'b0; play_req = 1'b0;
    tick(); tick();
    check_value("rst_state",  {30'h0, state}, 32'd0);
    check_value("rst_length", {27'h0, length}, 32'd0);
    check_value("rst_full",   {31'h0, full}, 32'd0);
    check_value("rst_done",   {31'h0, done}, 32'd0);
    check_value("rst_valid",  {31'h0, data_valid_out}, 32'd0);
    check_value("rst_data",   {16'h0, data_out}, 32'd0);
    reset = 1'b0;
    tick();

    // 1) async reset in the middle of a recording
    record = 1'b1; tick(); record = 1'b0;
    check_value("t1_state_rec", {30'h0, state}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h00F0 + 16'(i); data_valid_in = 1'b1; tick();
    end
    data_valid_in = 1'b0;
    check_value("t1_len5", {27'h0, length}, 32'd5);
    #2 reset = 1'b1;
    #1;
    check_value("t1_async_state",  {30'h0, state}, 32'd0);
    check_value("t1_async_length", {27'h0, length}, 32'd0);
    check_value("t1_async_full",   {31'h0, full}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 4) play with nothing recorded
    done_before = done_cnt; valid_before = valid_cnt;
    play = 1'b1; tick(); play = 1'b0;
    check_value("t4_done",  {31'h0, done}, 32'd1);
    check_value("t4_state", {30'h0, state}, 32'd0);
    check_value("t4_valid", {31'h0, data_valid_out}, 32'd0);
    tick();
    check_value("t4_done_clr", {31'h0, done}, 32'd0);
    tick();
    check_value("t4_done_once", done_cnt - done_before, 32'd1);
    check_value("t4_no_valid", valid_cnt - valid_before, 32'd0);

    // 2) record 8 words with idle gaps, then stop
    record = 1'b1; tick(); record = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      data_in = 16'(i); data_valid_in = 1'b1; tick();
      data_valid_in = 1'b0; data_in = 16'hDEAD; tick();
    end
    check_value("t2_state_rec", {30'h0, state}, 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check_value("t2_length", {27'h0, length}, 32'd8);
    check_value("t2_state",  {30'h0, state}, 32'd0);
    check_value("t2_full",   {31'h0, full}, 32'd0);

    // 3) play back with requests 3 cycles apart
    done_before = done_cnt;
    play = 1'b1; tick(); play = 1'b0;
    check_value("t3_state_play", {30'h0, state}, 32'd2);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(16'(i));
      play_req = 1'b1; tick(); play_req = 1'b0;
      check_value("t3_latency", {31'h0, data_valid_out}, 32'd1);
      check_value("t3_done", {31'h0, done}, (i == 8) ? 32'd1 : 32'd0);
      tick();
      check_value("t3_hold", {16'h0, data_out}, 32'(i));
      tick();
    end
    check_value("t3_state_end", {30'h0, state}, 32'd0);
    check_value("t3_done_once", done_cnt - done_before, 32'd1);
    check_value("t3_q_empty", exp_q.size(), 32'd0);

    // 5) overfill: 20 back-to-back strobes into a 16-word memory
    record = 1'b1; tick(); record = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = 16'hA000 + 16'(i); data_valid_in = 1'b1; tick();
      if (i == 14) check_value("t5_not_full_yet", {31'h0, full}, 32'd0);
      if (i == 15) begin
        check_value("t5_full",   {31'h0, full}, 32'd1);
        check_value("t5_state",  {30'h0, state}, 32'd0);
        check_value("t5_len16",  {27'h0, length}, 32'd16);
      end
    end
    data_valid_in = 1'b0;
    check_value("t5_len_after", {27'h0, length}, 32'd16);
    check_value("t5_full_sticky", {31'h0, full}, 32'd1);
    done_before = done_cnt;
    play = 1'b1; tick(); play = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(16'hA000 + 16'(i));
      play_req = 1'b1; tick();
    end
    play_req = 1'b0;
    check_value("t5_done", {31'h0, done}, 32'd1);
    check_value("t5_state_end", {30'h0, state}, 32'd0);
    tick();
    check_value("t5_done_once", done_cnt - done_before, 32'd1);
    check_value("t5_q_empty", exp_q.size(), 32'd0);

    // 6) record+play together, then abort a playback
    record = 1'b1; play = 1'b1; tick(); record = 1'b0; play = 1'b0;
    check_value("t6_record_wins", {30'h0, state}, 32'd1);
    check_value("t6_full_clr", {31'h0, full}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      data_in = 16'hB000 + 16'(i); data_valid_in = 1'b1; tick();
    end
    data_valid_in = 1'b0;
    stop = 1'b1; data_in = 16'hB004; data_valid_in = 1'b1; tick();
    stop = 1'b0; data_valid_in = 1'b0;
    check_value("t6_len", {27'h0, length}, 32'd5);
    done_before = done_cnt; valid_before = valid_cnt;
    play = 1'b1; tick(); play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'hB000 + 16'(i));
      play_req = 1'b1; tick();
    end
    play_req = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check_value("t6_state", {30'h0, state}, 32'd0);
    tick(); tick();
    check_value("t6_valid_cnt", valid_cnt - valid_before, 32'd3);
    check_value("t6_no_done", done_cnt - done_before, 32'd0);
    check_value("t6_q_empty", exp_q.size(), 32'd0);
    check_value("t6_len_kept", {27'h0, length}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
